// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals seen by the hazard controller.
// master = datapath, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rsrc1_in_id;
  logic [4:0]       Rsrc2_in_id;
  logic             use_rs1_in_id;
  logic             use_rs2_in_id;
  logic             halt_in_id;
  logic [4:0]       Rsrc1_in_ex;
  logic [4:0]       Rsrc2_in_ex;
  logic [4:0]       Rdst_in_ex;
  logic             RWrEn_in_ex;
  logic [1:0]       WBSel_in_ex;
  logic [4:0]       Rdst_in_mem;
  logic             RWrEn_in_mem;
  logic [4:0]       Rdst_in_wb;
  logic             RWrEn_in_wb;
  logic             redirect_in_ex;
  logic             stall_if;
  logic             stall_id;
  logic             flush_if_id;
  logic             bubble_ex;
  logic [1:0]       FwdA_sel;
  logic [1:0]       FwdB_sel;
  logic             halt_out;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output Rsrc1_in_id, Rsrc2_in_id,
    output use_rs1_in_id, use_rs2_in_id,
    output halt_in_id,
    output Rsrc1_in_ex, Rsrc2_in_ex,
    output Rdst_in_ex, RWrEn_in_ex, WBSel_in_ex,
    output Rdst_in_mem, RWrEn_in_mem,
    output Rdst_in_wb, RWrEn_in_wb,
    output redirect_in_ex,
    input  stall_if, stall_id,
    input  flush_if_id, bubble_ex,
    input  FwdA_sel, FwdB_sel,
    input  halt_out, stall_count
  );

  modport slave (
    input  Rsrc1_in_id, Rsrc2_in_id,
    input  use_rs1_in_id, use_rs2_in_id,
    input  halt_in_id,
    input  Rsrc1_in_ex, Rsrc2_in_ex,
    input  Rdst_in_ex, RWrEn_in_ex, WBSel_in_ex,
    input  Rdst_in_mem, RWrEn_in_mem,
    input  Rdst_in_wb, RWrEn_in_wb,
    input  redirect_in_ex,
    output stall_if, stall_id,
    output flush_if_id, bubble_ex,
    output FwdA_sel, FwdB_sel,
    output halt_out, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection, operand forwarding and halt drain
// sequencing for the 5-stage pipeline.
module hazard_ctrl #(
  parameter int DRAIN_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);
  localparam int DW = $clog2(DRAIN_DEPTH + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             halt_out_q, halt_out_d;

  logic       stall, flush, bubble;
  logic [1:0] fwd_a, fwd_b;
  logic       luh;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_mem,
    input logic       wen_mem,
    input logic [4:0] rd_wb,
    input logic       wen_wb
  );
    logic [1:0] s;
    s = 2'b00;
    if (!wen_mem && rd_mem != 5'd0 && rd_mem == rs)
      s = 2'b01;
    else if (!wen_wb && rd_wb != 5'd0 && rd_wb == rs)
      s = 2'b10;
    return s;
  endfunction

  always_comb begin
    luh = !hz.RWrEn_in_ex
       && hz.WBSel_in_ex == 2'b10
       && hz.Rdst_in_ex != 5'd0
       && ((hz.use_rs1_in_id
            && hz.Rdst_in_ex == hz.Rsrc1_in_id)
        || (hz.use_rs2_in_id
            && hz.Rdst_in_ex == hz.Rsrc2_in_id));
  end

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    stall_count_d = stall_count_q;
    halt_out_d    = halt_out_q;
    stall         = 1'b0;
    flush         = 1'b0;
    bubble        = 1'b0;
    fwd_a = fwd_sel(hz.Rsrc1_in_ex,
                    hz.Rdst_in_mem, hz.RWrEn_in_mem,
                    hz.Rdst_in_wb, hz.RWrEn_in_wb);
    fwd_b = fwd_sel(hz.Rsrc2_in_ex,
                    hz.Rdst_in_mem, hz.RWrEn_in_mem,
                    hz.Rdst_in_wb, hz.RWrEn_in_wb);
    unique case (state_q)
      RUN: begin
        // The ID instruction is wrong-path on a redirect.
        if (hz.redirect_in_ex) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (hz.halt_in_id) begin
          stall       = 1'b1;
          bubble      = 1'b1;
          drain_cnt_d = DW'(DRAIN_DEPTH);
          state_d     = DRAIN;
        end else if (luh) begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (stall_count_q != '1)
            stall_count_d = stall_count_q + 1'b1;
        end
      end
      DRAIN: begin
        stall       = 1'b1;
        bubble      = 1'b1;
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q == DW'(1)) begin
          state_d    = HALTED;
          halt_out_d = 1'b1;
        end
      end
      HALTED: begin
        stall      = 1'b1;
        bubble     = 1'b1;
        halt_out_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (!rst) begin
      stall  = 1'b0;
      flush  = 1'b1;
      bubble = 1'b1;
      fwd_a  = 2'b00;
      fwd_b  = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      drain_cnt_q   <= '0;
      stall_count_q <= '0;
      halt_out_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      stall_count_q <= stall_count_d;
      halt_out_q    <= halt_out_d;
    end
  end

  assign hz.stall_if    = stall;
  assign hz.stall_id    = stall;
  assign hz.flush_if_id = flush;
  assign hz.bubble_ex   = bubble;
  assign hz.FwdA_sel    = fwd_a;
  assign hz.FwdB_sel    = fwd_b;
  assign hz.halt_out    = halt_out_q;
  assign hz.stall_count = stall_count_q;
endmodule
